// File: rtl/zap_wb_arbiter.sv
// Two-master (code/data) Wishbone arbiter: registered external bus, ACK/ERR routing, stall watchdog.
// Defining ZAP_WB_ARB_RR_EN switches simultaneous-request ties from fixed D>C to round-robin.

module zap_wb_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic c_ack,
    input logic d_ack,
    input logic wb_stb,
    input logic wb_cyc
);
    a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(c_ack && d_ack));
    a_stb_in_cyc:    assert property (@(posedge clk) disable iff (!rst_n) (!wb_cyc) |-> (!wb_stb));
endmodule

module zap_wb_arbiter #(
    parameter logic [31:0] TIMEOUT = 32'd256,
    parameter logic [2:0]  CTI_EOB = 3'b111
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_c_wb_stb_nxt,
    input  logic        i_c_wb_cyc_nxt,
    input  logic [31:0] i_c_wb_adr_nxt,
    input  logic [31:0] i_c_wb_dat_nxt,
    input  logic [3:0]  i_c_wb_sel_nxt,
    input  logic        i_c_wb_wen_nxt,
    input  logic [2:0]  i_c_wb_cti_nxt,
    input  logic        i_d_wb_stb_nxt,
    input  logic        i_d_wb_cyc_nxt,
    input  logic [31:0] i_d_wb_adr_nxt,
    input  logic [31:0] i_d_wb_dat_nxt,
    input  logic [3:0]  i_d_wb_sel_nxt,
    input  logic        i_d_wb_wen_nxt,
    input  logic [2:0]  i_d_wb_cti_nxt,
    output logic        o_c_wb_ack,
    output logic        o_d_wb_ack,
    output logic        o_c_wb_err,
    output logic        o_d_wb_err,
    output logic        o_wb_stb,
    output logic        o_wb_cyc,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack
);
    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'd1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_C = 2'd1,
        ST_OWN_D = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    state_t        pick_s;
    logic [CW-1:0] cnt_r;
    logic          abort_d_r;
    logic          decision_s;
    logic          timeout_s;
    logic          tie_d_s;
    logic          stb_s, cyc_s, wen_s;
    logic [31:0]   adr_s, dat_s;
    logic [3:0]    sel_s;
    logic [2:0]    cti_s;
    logic          c_err_s, d_err_s;
    logic          unused_s;

    // Read data goes straight to both masters outside this block.
    assign unused_s = ^i_wb_dat;

`ifdef ZAP_WB_ARB_RR_EN
    logic last_d_r;

    assign tie_d_s = !last_d_r;

    // Record which side held the bus last so ties alternate.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_d_r <= 1'b0;
        end else if (((state_r == ST_OWN_C) || (state_r == ST_OWN_D)) && (state_nxt_s != state_r)) begin
            last_d_r <= (state_r == ST_OWN_D);
        end else begin
            last_d_r <= last_d_r;
        end
    end
`else
    assign tie_d_s = 1'b1;
`endif

    assign decision_s = (!o_wb_stb || i_wb_ack) && (state_r != ST_ABORT);
    assign timeout_s  = (TIMEOUT != 32'd0) && o_wb_stb && !i_wb_ack && (cnt_r == CNT_LAST);

    assign o_c_wb_ack = i_wb_ack && o_wb_stb && (state_r == ST_OWN_C);
    assign o_d_wb_ack = i_wb_ack && o_wb_stb && (state_r == ST_OWN_D);

    // Fresh grant when nobody keeps the bus.
    always_comb begin
        pick_s = ST_IDLE;
        if (i_c_wb_cyc_nxt && i_d_wb_cyc_nxt) begin
            pick_s = tie_d_s ? ST_OWN_D : ST_OWN_C;
        end else if (i_d_wb_cyc_nxt) begin
            pick_s = ST_OWN_D;
        end else if (i_c_wb_cyc_nxt) begin
            pick_s = ST_OWN_C;
        end else begin
            pick_s = ST_IDLE;
        end
    end

    // Next state: the owner keeps the bus while its cyc stays up, so bursts are never split.
    always_comb begin
        state_nxt_s = state_r;
        if (timeout_s) begin
            state_nxt_s = ST_ABORT;
        end else if (state_r == ST_ABORT) begin
            if (abort_d_r ? !i_d_wb_cyc_nxt : !i_c_wb_cyc_nxt) begin
                state_nxt_s = ST_IDLE;
            end else begin
                state_nxt_s = ST_ABORT;
            end
        end else if (decision_s) begin
            case (state_r)
                ST_OWN_C: state_nxt_s = i_c_wb_cyc_nxt ? ST_OWN_C : pick_s;
                ST_OWN_D: state_nxt_s = i_d_wb_cyc_nxt ? ST_OWN_D : pick_s;
                default:  state_nxt_s = pick_s;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Bus values loaded at the next edge follow the upcoming owner.
    always_comb begin
        stb_s = 1'b0;
        cyc_s = 1'b0;
        wen_s = 1'b0;
        cti_s = CTI_EOB;
        adr_s = o_wb_adr;
        dat_s = o_wb_dat;
        sel_s = o_wb_sel;
        case (state_nxt_s)
            ST_OWN_C: begin
                stb_s = i_c_wb_stb_nxt;
                cyc_s = i_c_wb_cyc_nxt;
                wen_s = i_c_wb_wen_nxt;
                cti_s = i_c_wb_cti_nxt;
                adr_s = i_c_wb_adr_nxt;
                dat_s = i_c_wb_dat_nxt;
                sel_s = i_c_wb_sel_nxt;
            end
            ST_OWN_D: begin
                stb_s = i_d_wb_stb_nxt;
                cyc_s = i_d_wb_cyc_nxt;
                wen_s = i_d_wb_wen_nxt;
                cti_s = i_d_wb_cti_nxt;
                adr_s = i_d_wb_adr_nxt;
                dat_s = i_d_wb_dat_nxt;
                sel_s = i_d_wb_sel_nxt;
            end
            default: begin
                stb_s = 1'b0;
                cyc_s = 1'b0;
            end
        endcase
        c_err_s = timeout_s && (state_r == ST_OWN_C);
        d_err_s = timeout_s && (state_r == ST_OWN_D);
    end

    // State, watchdog counter and the identity of an aborted master.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            abort_d_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (timeout_s || !o_wb_stb || i_wb_ack) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CW'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (timeout_s) begin
                abort_d_r <= (state_r == ST_OWN_D);
            end else begin
                abort_d_r <= abort_d_r;
            end
        end
    end

    // Registered external bus and error pulses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_stb   <= 1'b0;
            o_wb_cyc   <= 1'b0;
            o_wb_wen   <= 1'b0;
            o_wb_adr   <= 32'd0;
            o_wb_dat   <= 32'd0;
            o_wb_sel   <= 4'd0;
            o_wb_cti   <= CTI_EOB;
            o_c_wb_err <= 1'b0;
            o_d_wb_err <= 1'b0;
        end else begin
            o_wb_stb   <= stb_s;
            o_wb_cyc   <= cyc_s;
            o_wb_wen   <= wen_s;
            o_wb_adr   <= adr_s;
            o_wb_dat   <= dat_s;
            o_wb_sel   <= sel_s;
            o_wb_cti   <= cti_s;
            o_c_wb_err <= c_err_s;
            o_d_wb_err <= d_err_s;
        end
    end

    zap_wb_arbiter_chk u_chk (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .c_ack  (o_c_wb_ack),
        .d_ack  (o_d_wb_ack),
        .wb_stb (o_wb_stb),
        .wb_cyc (o_wb_cyc)
    );

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Self-checking bench for zap_wb_arbiter: directed table, corner sequences, randomized model check.

module tb_zap_wb_arbiter;
    logic        i_clk = 1'b0;
    logic        rst_n;
    logic        c_cyc, c_stb, c_wen, d_cyc, d_stb, d_wen, wb_ack;
    logic [31:0] c_adr, c_dat, d_adr, d_dat, wb_dat;
    logic [3:0]  c_sel, d_sel;
    logic [2:0]  c_cti, d_cti;

    logic        a_cack, a_dack, a_cerr, a_derr, a_stb, a_cyc, a_wen;
    logic [31:0] a_adr, a_dat;
    logic [3:0]  a_sel;
    logic [2:0]  a_cti;
    logic        z_cack, z_dack, z_cerr, z_derr, z_stb, z_cyc, z_wen;
    logic [31:0] z_adr, z_dat;
    logic [3:0]  z_sel;
    logic [2:0]  z_cti;

    int n_chk = 0;
    int n_fail = 0;
    int good, rate;
    logic rc, rd;

    typedef struct {
        logic        c;
        logic        d;
        logic        ack;
        logic        stb;
        logic [31:0] adr;
        logic        cack;
        logic        dack;
    } vec_t;
    vec_t vt[15];

    // reference model state
    int          m_own;
    int          m_wait;
    logic        m_abort, m_abort_d;
    logic        m_stb, m_cyc, m_wen, m_cerr, m_derr;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic [2:0]  m_cti;

    always #5 i_clk = ~i_clk;

    zap_wb_arbiter #(.TIMEOUT(32'd8)) u_dut8 (
        .i_clk(i_clk), .i_reset_n(rst_n),
        .i_c_wb_stb_nxt(c_stb), .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_adr_nxt(c_adr), .i_c_wb_dat_nxt(c_dat),
        .i_c_wb_sel_nxt(c_sel), .i_c_wb_wen_nxt(c_wen), .i_c_wb_cti_nxt(c_cti),
        .i_d_wb_stb_nxt(d_stb), .i_d_wb_cyc_nxt(d_cyc), .i_d_wb_adr_nxt(d_adr), .i_d_wb_dat_nxt(d_dat),
        .i_d_wb_sel_nxt(d_sel), .i_d_wb_wen_nxt(d_wen), .i_d_wb_cti_nxt(d_cti),
        .o_c_wb_ack(a_cack), .o_d_wb_ack(a_dack), .o_c_wb_err(a_cerr), .o_d_wb_err(a_derr),
        .o_wb_stb(a_stb), .o_wb_cyc(a_cyc), .o_wb_wen(a_wen), .o_wb_adr(a_adr), .o_wb_dat(a_dat),
        .o_wb_sel(a_sel), .o_wb_cti(a_cti), .i_wb_dat(wb_dat), .i_wb_ack(wb_ack)
    );

    zap_wb_arbiter #(.TIMEOUT(32'd0)) u_dut0 (
        .i_clk(i_clk), .i_reset_n(rst_n),
        .i_c_wb_stb_nxt(c_stb), .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_adr_nxt(c_adr), .i_c_wb_dat_nxt(c_dat),
        .i_c_wb_sel_nxt(c_sel), .i_c_wb_wen_nxt(c_wen), .i_c_wb_cti_nxt(c_cti),
        .i_d_wb_stb_nxt(d_stb), .i_d_wb_cyc_nxt(d_cyc), .i_d_wb_adr_nxt(d_adr), .i_d_wb_dat_nxt(d_dat),
        .i_d_wb_sel_nxt(d_sel), .i_d_wb_wen_nxt(d_wen), .i_d_wb_cti_nxt(d_cti),
        .o_c_wb_ack(z_cack), .o_d_wb_ack(z_dack), .o_c_wb_err(z_cerr), .o_d_wb_err(z_derr),
        .o_wb_stb(z_stb), .o_wb_cyc(z_cyc), .o_wb_wen(z_wen), .o_wb_adr(z_adr), .o_wb_dat(z_dat),
        .o_wb_sel(z_sel), .o_wb_cti(z_cti), .i_wb_dat(wb_dat), .i_wb_ack(wb_ack)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp8(input string name, input logic stb, input logic cyc, input logic [31:0] adr,
                        input logic cack, input logic dack, input logic cerr, input logic derr);
        chk(name, {a_stb, a_cyc, a_adr, a_cack, a_dack, a_cerr, a_derr},
                  {stb, cyc, adr, cack, dack, cerr, derr});
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_c(input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
        c_cyc = cyc; c_stb = cyc; c_adr = adr; c_dat = adr ^ 32'hC0DE_0000;
        c_sel = 4'hF; c_wen = 1'b0; c_cti = cti;
    endtask

    task automatic set_d(input logic cyc, input logic [31:0] adr, input logic wen);
        d_cyc = cyc; d_stb = cyc; d_adr = adr; d_dat = adr ^ 32'hDA7A_0000;
        d_sel = 4'hF; d_wen = wen; d_cti = 3'b111;
    endtask

    task automatic idle_in();
        set_c(1'b0, 32'h0, 3'b111);
        set_d(1'b0, 32'h0, 1'b0);
        wb_ack = 1'b0;
        wb_dat = 32'h0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic m_reset();
        m_own = 0; m_wait = 0; m_abort = 1'b0; m_abort_d = 1'b0;
        m_stb = 1'b0; m_cyc = 1'b0; m_wen = 1'b0; m_cerr = 1'b0; m_derr = 1'b0;
        m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0; m_cti = 3'b111;
    endtask

    // Advance the model by one clock using the inputs currently applied (TIMEOUT = 8).
    task automatic m_step();
        int   nown;
        logic to;
        nown = m_own;
        to = m_stb && !wb_ack && (m_wait == 7);
        m_cerr = to && (m_own == 1);
        m_derr = to && (m_own == 2);
        if (to) begin
            m_abort = 1'b1;
            m_abort_d = (m_own == 2);
            nown = 0;
        end else if (m_abort) begin
            if (!(m_abort_d ? d_cyc : c_cyc)) m_abort = 1'b0;
            nown = 0;
        end else if (!m_stb || wb_ack) begin
            if (m_own == 1 && c_cyc)      nown = 1;
            else if (m_own == 2 && d_cyc) nown = 2;
            else if (d_cyc)               nown = 2;
            else if (c_cyc)               nown = 1;
            else                          nown = 0;
        end
        m_wait = (!to && m_stb && !wb_ack) ? m_wait + 1 : 0;
        m_own = nown;
        if (nown == 1) begin
            m_stb = c_stb; m_cyc = c_cyc; m_wen = c_wen; m_adr = c_adr; m_dat = c_dat; m_sel = c_sel; m_cti = c_cti;
        end else if (nown == 2) begin
            m_stb = d_stb; m_cyc = d_cyc; m_wen = d_wen; m_adr = d_adr; m_dat = d_dat; m_sel = d_sel; m_cti = d_cti;
        end else begin
            m_stb = 1'b0; m_cyc = 1'b0; m_wen = 1'b0; m_cti = 3'b111;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle_in();
        rst_n = 1'b0;
        @(negedge i_clk);
        chk("reset_dut8", {a_stb, a_cyc, a_wen, a_adr, a_dat, a_sel, a_cti, a_cack, a_dack, a_cerr, a_derr},
                          {3'b000, 32'h0, 32'h0, 4'h0, 3'b111, 4'b0000});
        chk("reset_dut0", {z_stb, z_cyc, z_wen, z_adr, z_dat, z_sel, z_cti, z_cack, z_dack, z_cerr, z_derr},
                          {3'b000, 32'h0, 32'h0, 4'h0, 3'b111, 4'b0000});
        do_reset();

        // ---------------- table: D read, tie and zero-bubble handover ----------------
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hC000, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hC000, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hC000, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hC000, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            set_c(vt[i].c, 32'hC000, 3'b111);
            set_d(vt[i].d, 32'h1000, 1'b0);
            wb_ack = vt[i].ack;
            @(negedge i_clk);
            exp8($sformatf("table_row%0d", i), vt[i].stb, vt[i].stb, vt[i].adr, vt[i].cack, vt[i].dack, 1'b0, 1'b0);
            tick();
        end

        // ---------------- C 4-beat burst, D waits ----------------
        idle_in();
        set_c(1'b1, 32'h2000, 3'b010);
        @(negedge i_clk);
        exp8("burst_req", 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) set_c(1'b1, 32'h2000 + 32'(k + 1) * 32'd4, (k == 2) ? 3'b111 : 3'b010);
            else       set_c(1'b0, 32'h0, 3'b111);
            set_d(1'b1, 32'h1000, 1'b0);
            wb_ack = 1'b1;
            @(negedge i_clk);
            exp8($sformatf("burst_beat%0d", k), 1'b1, 1'b1, 32'h2000 + 32'(k) * 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("burst_cti%0d", k), a_cti, (k == 3) ? 3'b111 : 3'b010);
            tick();
        end
        set_d(1'b0, 32'h1000, 1'b0);
        wb_ack = 1'b1;
        @(negedge i_clk);
        exp8("burst_then_d", 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle_in();
        @(negedge i_clk);
        exp8("burst_idle", 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // ---------------- watchdog abort, TIMEOUT = 8 ----------------
        set_d(1'b1, 32'h3000, 1'b1);
        set_c(1'b1, 32'hC000, 3'b111);
        @(negedge i_clk);
        exp8("to_req", 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            exp8($sformatf("to_wait%0d", i), 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        wb_ack = 1'b1;
        @(negedge i_clk);
        exp8("to_abort", 1'b0, 1'b0, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        @(negedge i_clk);
        exp8("to_err_once", 1'b0, 1'b0, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(1'b0, 32'h0, 1'b0);
        wb_ack = 1'b0;
        @(negedge i_clk);
        exp8("to_release", 1'b0, 1'b0, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge i_clk);
        exp8("to_idle", 1'b0, 1'b0, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_c(1'b0, 32'h0, 3'b111);
        wb_ack = 1'b1;
        @(negedge i_clk);
        exp8("to_c_grant", 1'b1, 1'b1, 32'hC000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();

        // ---------------- async reset mid-burst ----------------
        set_c(1'b1, 32'h2000, 3'b010);
        tick();
        set_c(1'b1, 32'h2004, 3'b010);
        wb_ack = 1'b1;
        tick();
        @(negedge i_clk);
        chk("rst_pre", {a_stb, a_cyc, a_cti}, {1'b1, 1'b1, 3'b010});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_dut8", {a_stb, a_cyc, a_cti}, {1'b0, 1'b0, 3'b111});
        chk("rst_mid_dut0", {z_stb, z_cyc, z_cti}, {1'b0, 1'b0, 3'b111});
        idle_in();
        @(negedge i_clk);
        rst_n = 1'b1;
        tick();
        set_d(1'b1, 32'h1000, 1'b0);
        wb_ack = 1'b1;
        @(negedge i_clk);
        exp8("rst_first_req", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(1'b0, 32'h0, 1'b0);
        @(negedge i_clk);
        exp8("rst_granted", 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // ---------------- TIMEOUT = 0: no watchdog ----------------
        do_reset();
        set_d(1'b1, 32'h4000, 1'b0);
        @(negedge i_clk);
        chk("t0_req", z_stb, 1'b0);
        tick();
        good = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge i_clk);
            if (z_stb && z_cyc && !z_derr && !z_cerr && !z_dack && z_adr == 32'h4000) good++;
            tick();
        end
        chk("t0_hold", 128'(good), 128'd1000);
        set_d(1'b0, 32'h0, 1'b0);
        wb_ack = 1'b1;
        @(negedge i_clk);
        chk("t0_ack", {z_stb, z_dack, z_derr}, {1'b1, 1'b1, 1'b0});
        tick();
        idle_in();
        @(negedge i_clk);
        chk("t0_done", z_stb, 1'b0);
        tick();

        // ---------------- randomized check against the model ----------------
        do_reset();
        m_reset();
        rc = 1'b0;
        rd = 1'b0;
        rate = 4;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 40 == 0) rate = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) rc = !rc;
            if ($urandom_range(0, 7) == 0) rd = !rd;
            c_cyc = rc; c_stb = rc && ($urandom_range(0, 7) != 0);
            d_cyc = rd; d_stb = rd && ($urandom_range(0, 7) != 0);
            c_adr = $urandom; c_dat = $urandom; c_sel = 4'($urandom_range(0, 15));
            d_adr = $urandom; d_dat = $urandom; d_sel = 4'($urandom_range(0, 15));
            c_wen = 1'($urandom_range(0, 1)); d_wen = 1'($urandom_range(0, 1));
            c_cti = 3'($urandom_range(0, 7)); d_cti = 3'($urandom_range(0, 7));
            wb_ack = ($urandom_range(0, 7) < rate);
            wb_dat = $urandom;
            @(negedge i_clk);
            chk("random", {a_stb, a_cyc, a_wen, a_adr, a_dat, a_sel, a_cti, a_cack, a_dack, a_cerr, a_derr},
                          {m_stb, m_cyc, m_wen, m_adr, m_dat, m_sel, m_cti,
                           wb_ack && m_stb && (m_own == 1), wb_ack && m_stb && (m_own == 2), m_cerr, m_derr});
            m_step();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
